// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding and default parameters for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT} state_t;
  localparam int TIMEOUT_DEF = 15;
  localparam int FAIR_MAX_DEF = 2;
endpackage

// File: rtl/mem_arbiter_timer.sv
// arb_timer: counts wait cycles since the last grant and flags a memory timeout
module arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  logic [15:0] r_cnt;
  // Cleared on every grant, advances on each waiting cycle without a memory response
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 16'd1;
  assign o_expired = i_en && r_cnt == 16'(TIMEOUT - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data requesters
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int FAIR_MAX = FAIR_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);
  localparam logic [7:0] FM = 8'(FAIR_MAX);
  state_t r_state, w_next;
  logic [7:0] r_fair;
  logic [15:0] r_addr, r_wdata, r_if_rdata, r_dm_rdata, w_addr, w_wdata;
  logic r_wr, r_if_done, r_dm_done, r_err;
  logic w_dm_bad, w_can, w_gnt_if, w_gnt_dm, w_grant, w_expire;
  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .i_clr(w_grant),
    .i_en(r_state != IDLE && !mem_done),
    .o_expired(w_expire)
  );
  // State register
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // Next state: grant from IDLE, back to IDLE on response or timeout
  always_comb
    w_next = w_gnt_if ? IF_WAIT : w_gnt_dm ? DM_WAIT :
             (r_state != IDLE && (mem_done || w_expire)) ? IDLE : r_state;
  // Arbitration and memory command outputs; no grant while a done pulse is out
  always_comb begin
    w_dm_bad = dm_rd && dm_wr;
    w_can = r_state == IDLE && !rst && !r_if_done && !r_dm_done;
    w_gnt_dm = w_can && (dm_rd || dm_wr) && !w_dm_bad && !(if_req && r_fair == FM);
    w_gnt_if = w_can && if_req && !w_gnt_dm;
    w_grant = w_gnt_if || w_gnt_dm;
    w_addr = w_gnt_if ? if_addr : dm_addr;
    w_wdata = w_gnt_dm ? dm_wdata : '0;
    mem_rd = w_gnt_if || (w_gnt_dm && dm_rd);
    mem_wr = w_gnt_dm && dm_wr;
    mem_addr = w_grant ? w_addr : r_addr;
    mem_wdata = w_grant ? w_wdata : r_wdata;
    if_stall = !rst && if_req && !r_if_done;
    dm_stall = !rst && (dm_rd || dm_wr) && !r_dm_done;
  end
  // Transaction capture, fairness count, response capture and sticky error
  always_ff @(posedge clk)
    if (rst) begin
      r_addr <= '0;
      r_wdata <= '0;
      r_wr <= 1'b0;
      r_fair <= '0;
      r_if_done <= 1'b0;
      r_dm_done <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_addr <= w_addr;
        r_wdata <= w_wdata;
        r_wr <= mem_wr;
      end
      if (w_gnt_if) r_fair <= '0;
      else if (w_gnt_dm && if_req) r_fair <= r_fair == FM ? FM : r_fair + 8'd1;
      r_if_done <= r_state == IF_WAIT && mem_done;
      r_dm_done <= r_state == DM_WAIT && mem_done;
      if (r_state == IF_WAIT && mem_done) r_if_rdata <= mem_rdata;
      if (r_state == DM_WAIT && mem_done && !r_wr) r_dm_rdata <= mem_rdata;
      r_err <= r_err || w_expire || (r_state == IDLE && (mem_done || w_dm_bad));
    end
  assign if_done = r_if_done;
  assign dm_done = r_dm_done;
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;
  assign err = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 0, rst = 1;
  logic if_req = 0, if_done, if_stall;
  logic [15:0] if_addr = 0, if_rdata;
  logic dm_rd = 0, dm_wr = 0, dm_done, dm_stall;
  logic [15:0] dm_addr = 0, dm_wdata = 0, dm_rdata;
  logic mem_rd, mem_wr, mem_done = 0, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [15:0] mem [16];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst = 1; if_req = 0; dm_rd = 0; dm_wr = 0; mem_done = 0; mem_rdata = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    smp();
    checks++;
    if ({mem_rd, mem_wr, if_done, dm_done, if_stall, dm_stall, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b need 0000000", {mem_rd, mem_wr, if_done, dm_done, if_stall, dm_stall, err});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h need 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
    end
    tick(); if_req = 1; if_addr = 16'h0010; smp();
    checks++;
    if (mem_rd !== 1'b0 || if_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: mem_rd=%b if_stall=%b need 0 0", mem_rd, if_stall);
    end
  endtask

  task automatic test_fetch();
    tick(); rst = 0; smp();
    checks++;
    if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0010 || if_stall !== 1'b1) begin
      errors++;
      $display("FAIL fetch_grant: rd=%b wr=%b addr=%h stall=%b need 1 0 0010 1", mem_rd, mem_wr, mem_addr, if_stall);
    end
    for (int i = 0; i < 2; i++) begin
      tick(); smp();
      checks++;
      if (mem_rd !== 1'b0 || mem_addr !== 16'h0010 || if_done !== 1'b0) begin
        errors++;
        $display("FAIL fetch_hold: rd=%b addr=%h done=%b need 0 0010 0", mem_rd, mem_addr, if_done);
      end
    end
    tick(); mem_done = 1; mem_rdata = 16'hBEEF; smp();
    checks++;
    if (if_done !== 1'b0 || if_stall !== 1'b1) begin
      errors++;
      $display("FAIL fetch_early: done=%b stall=%b need 0 1", if_done, if_stall);
    end
    tick(); mem_done = 0; mem_rdata = 0; smp();
    checks++;
    if (if_done !== 1'b1 || if_rdata !== 16'hBEEF || if_stall !== 1'b0 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done: done=%b rdata=%h stall=%b rd=%b need 1 beef 0 0", if_done, if_rdata, if_stall, mem_rd);
    end
    tick(); if_req = 0; smp();
    checks++;
    if (if_done !== 1'b0 || if_rdata !== 16'hBEEF || if_stall !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL fetch_after: done=%b rdata=%h stall=%b err=%b need 0 beef 0 0", if_done, if_rdata, if_stall, err);
    end
  endtask

  task automatic test_priority();
    tick(); if_req = 1; if_addr = 16'h0020; dm_rd = 1; dm_addr = 16'h0030; smp();
    checks++;
    if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0030) begin
      errors++;
      $display("FAIL prio_data_first: rd=%b wr=%b addr=%h need 1 0 0030", mem_rd, mem_wr, mem_addr);
    end
    tick(); mem_done = 1; mem_rdata = 16'h1111; smp();
    tick(); mem_done = 0; smp();
    checks++;
    if (dm_done !== 1'b1 || dm_rdata !== 16'h1111 || if_done !== 1'b0 || mem_rd !== 1'b0 || if_stall !== 1'b1) begin
      errors++;
      $display("FAIL prio_dm_done: dm_done=%b rdata=%h if_done=%b rd=%b if_stall=%b need 1 1111 0 0 1",
               dm_done, dm_rdata, if_done, mem_rd, if_stall);
    end
    tick(); dm_rd = 0; smp();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h0020) begin
      errors++;
      $display("FAIL prio_fetch_second: rd=%b addr=%h need 1 0020", mem_rd, mem_addr);
    end
    tick(); mem_done = 1; mem_rdata = 16'h2222; smp();
    tick(); mem_done = 0; smp();
    checks++;
    if (if_done !== 1'b1 || if_rdata !== 16'h2222 || dm_done !== 1'b0 || dm_rdata !== 16'h1111) begin
      errors++;
      $display("FAIL prio_if_done: if_done=%b if_rdata=%h dm_done=%b dm_rdata=%h need 1 2222 0 1111",
               if_done, if_rdata, dm_done, dm_rdata);
    end
    tick(); if_req = 0;
  endtask

  task automatic test_fairness();
    int fair = 0;
    bit exp_if;
    logic [15:0] exp_addr, rd;
    tick();
    if_req = 1; if_addr = 16'($urandom_range(0, 255));
    dm_wr = 1; dm_addr = 16'($urandom_range(0, 255)); dm_wdata = 16'($urandom);
    for (int t = 0; t < 6; t++) begin
      exp_if = fair == 2;
      exp_addr = exp_if ? if_addr : dm_addr;
      smp();
      checks++;
      if (mem_rd !== exp_if || mem_wr !== !exp_if || mem_addr !== exp_addr || (!exp_if && mem_wdata !== dm_wdata)) begin
        errors++;
        $display("FAIL fair_grant[%0d]: rd=%b wr=%b addr=%h need %b %b %h", t, mem_rd, mem_wr, mem_addr,
                 exp_if, !exp_if, exp_addr);
      end
      fair = exp_if ? 0 : (fair < 2 ? fair + 1 : 2);
      rd = 16'($urandom);
      tick(); mem_done = 1; mem_rdata = rd; smp();
      tick(); mem_done = 0; smp();
      checks++;
      if (exp_if ? (if_done !== 1'b1 || dm_done !== 1'b0 || if_rdata !== rd)
                 : (dm_done !== 1'b1 || if_done !== 1'b0 || dm_rdata !== 16'h1111)) begin
        errors++;
        $display("FAIL fair_done[%0d]: if_done=%b dm_done=%b if_rdata=%h dm_rdata=%h fetch=%b rd=%h (write keeps 1111)",
                 t, if_done, dm_done, if_rdata, dm_rdata, exp_if, rd);
      end
      tick();
      if (exp_if) if_addr = 16'($urandom_range(0, 255));
      else begin dm_addr = 16'($urandom_range(0, 255)); dm_wdata = 16'($urandom); end
      if (t == 5) begin if_req = 0; dm_wr = 0; end
    end
  endtask

  task automatic test_random();
    int fair = 0, mcnt = 0;
    bit busy = 0, due = 0, exp_done = 0, owner_dm = 0, cur_wr = 0, if_fin = 0, dm_fin = 0;
    bit w, exp_dm, exp_if, exp_rd, exp_wr, ex_is, ex_ds;
    logic [15:0] g_addr = 0, g_wdata = 0, due_data = 0, last_dm = 0, exp_addr;
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 16'(i) * 16'h1111 ^ 16'h0F0F;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) tick();
      rst = 0;
      if (!if_req || if_fin) begin
        if_req = cyc < 570 ? 1'($urandom_range(0, 1)) : 1'b0;
        if_addr = 16'($urandom_range(0, 15));
      end
      if (!(dm_rd || dm_wr) || dm_fin) begin
        w = 1'($urandom_range(0, 1));
        exp_dm = cyc < 570 ? 1'($urandom_range(0, 1)) : 1'b0;
        dm_rd = exp_dm && !w; dm_wr = exp_dm && w;
        dm_addr = 16'($urandom_range(0, 15)); dm_wdata = 16'($urandom);
      end
      if_fin = 0; dm_fin = 0;
      exp_done = due; due = 0;
      mem_done = 0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mem_done = 1;
          if (cur_wr) mem[g_addr[3:0]] = g_wdata;
          mem_rdata = cur_wr ? 16'($urandom) : mem[g_addr[3:0]];
          due = 1; due_data = mem_rdata;
        end
      end
      smp();
      ex_is = if_req && !(exp_done && !owner_dm);
      ex_ds = (dm_rd || dm_wr) && !(exp_done && owner_dm);
      checks++;
      if (if_stall !== ex_is || dm_stall !== ex_ds) begin
        errors++;
        $display("FAIL rand_stall@%0d: if_stall=%b dm_stall=%b need %b %b", cyc, if_stall, dm_stall, ex_is, ex_ds);
      end
      if (exp_done) begin
        checks++;
        if (owner_dm ? (dm_done !== 1'b1 || if_done !== 1'b0 || dm_rdata !== (cur_wr ? last_dm : due_data))
                     : (if_done !== 1'b1 || dm_done !== 1'b0 || if_rdata !== due_data)) begin
          errors++;
          $display("FAIL rand_done@%0d: if_done=%b dm_done=%b if_rdata=%h dm_rdata=%h need data=%b wr=%b val=%h last=%h",
                   cyc, if_done, dm_done, if_rdata, dm_rdata, owner_dm, cur_wr, due_data, last_dm);
        end
        if (owner_dm && !cur_wr) last_dm = due_data;
        if (owner_dm) dm_fin = 1; else if_fin = 1;
        busy = 0;
        checks++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
          errors++;
          $display("FAIL rand_nogrant@%0d: rd=%b wr=%b need 0 0", cyc, mem_rd, mem_wr);
        end
      end else begin
        checks++;
        if (if_done !== 1'b0 || dm_done !== 1'b0) begin
          errors++;
          $display("FAIL rand_spurious@%0d: if_done=%b dm_done=%b need 0 0", cyc, if_done, dm_done);
        end
        if (!busy) begin
          exp_dm = (dm_rd ^ dm_wr) && !(if_req && fair == 2);
          exp_if = if_req && !exp_dm;
          exp_rd = exp_if || (exp_dm && dm_rd);
          exp_wr = exp_dm && dm_wr;
          exp_addr = exp_if ? if_addr : dm_addr;
          checks++;
          if (mem_rd !== exp_rd || mem_wr !== exp_wr || ((exp_rd || exp_wr) && mem_addr !== exp_addr)) begin
            errors++;
            $display("FAIL rand_grant@%0d: rd=%b wr=%b addr=%h need %b %b %h", cyc, mem_rd, mem_wr, mem_addr,
                     exp_rd, exp_wr, exp_addr);
          end
          if (exp_rd || exp_wr) begin
            busy = 1; owner_dm = exp_dm; cur_wr = exp_wr; g_addr = exp_addr; g_wdata = dm_wdata;
            mcnt = $urandom_range(1, 4);
            fair = exp_if ? 0 : (if_req ? (fair < 2 ? fair + 1 : 2) : fair);
          end
        end else begin
          checks++;
          if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== g_addr || (cur_wr && mem_wdata !== g_wdata)) begin
            errors++;
            $display("FAIL rand_hold@%0d: rd=%b wr=%b addr=%h wdata=%h need 0 0 %h %h", cyc, mem_rd, mem_wr,
                     mem_addr, mem_wdata, g_addr, g_wdata);
          end
        end
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rand_err: err=%b need 0", err);
    end
    tick(); if_req = 0; dm_rd = 0; dm_wr = 0; mem_done = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    tick(); rst = 0; dm_rd = 1; dm_addr = 16'h0040; smp();
    checks++;
    if (mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL to_grant: rd=%b need 1", mem_rd);
    end
    for (int i = 1; i <= 15; i++) begin
      tick(); smp();
      checks++;
      if (err !== 1'b0 || dm_done !== 1'b0 || mem_rd !== 1'b0 || dm_stall !== 1'b1) begin
        errors++;
        $display("FAIL to_wait[%0d]: err=%b done=%b rd=%b stall=%b need 0 0 0 1", i, err, dm_done, mem_rd, dm_stall);
      end
    end
    tick(); smp();
    checks++;
    if (err !== 1'b1 || dm_done !== 1'b0 || mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL to_expire: err=%b done=%b rd=%b need 1 0 1", err, dm_done, mem_rd);
    end
    tick(); dm_rd = 0; smp();
    checks++;
    if (err !== 1'b1 || dm_done !== 1'b0) begin
      errors++;
      $display("FAIL to_sticky: err=%b done=%b need 1 0", err, dm_done);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    tick(); rst = 0; dm_rd = 1; dm_wr = 1; dm_addr = 16'h0060; smp();
    checks++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL cf_nogrant: rd=%b wr=%b err=%b need 0 0 0", mem_rd, mem_wr, err);
    end
    tick(); smp();
    checks++;
    if (err !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || dm_stall !== 1'b1) begin
      errors++;
      $display("FAIL cf_err: err=%b rd=%b wr=%b stall=%b need 1 0 0 1", err, mem_rd, mem_wr, dm_stall);
    end
    tick(); if_req = 1; if_addr = 16'h0070; smp();
    checks++;
    if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0070) begin
      errors++;
      $display("FAIL cf_fetch: rd=%b wr=%b addr=%h need 1 0 0070", mem_rd, mem_wr, mem_addr);
    end
    tick(); if_req = 0; dm_rd = 0; dm_wr = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(); rst = 0; dm_wr = 1; dm_addr = 16'h0050; dm_wdata = 16'hCAFE; smp();
    checks++;
    if (mem_wr !== 1'b1 || mem_addr !== 16'h0050 || mem_wdata !== 16'hCAFE) begin
      errors++;
      $display("FAIL rm_grant: wr=%b addr=%h wdata=%h need 1 0050 cafe", mem_wr, mem_addr, mem_wdata);
    end
    tick(); rst = 1; dm_wr = 0; dm_addr = 0; dm_wdata = 0; smp();
    tick(); rst = 0; smp();
    checks++;
    if ({mem_rd, mem_wr, if_done, dm_done, if_stall, dm_stall, err} !== 7'b0 ||
        {mem_addr, mem_wdata, if_rdata, dm_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL rm_zero: ctrl=%b data=%h need all 0", {mem_rd, mem_wr, if_done, dm_done, if_stall, dm_stall, err},
               {mem_addr, mem_wdata, if_rdata, dm_rdata});
    end
    tick(); mem_done = 1; mem_rdata = 16'h1234; smp();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rm_pre: err=%b need 0", err);
    end
    tick(); mem_done = 0; smp();
    checks++;
    if (err !== 1'b1 || dm_done !== 1'b0 || dm_rdata !== 16'h0) begin
      errors++;
      $display("FAIL rm_late: err=%b done=%b rdata=%h need 1 0 0000", err, dm_done, dm_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_fairness();
    test_random();
    test_timeout();
    test_conflict();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
